// File: rtl/serial_negate_unit.sv
// Digit-serial two's-complement pass/negate/abs/one's-complement unit.
// One operand per valid/ready transaction, DIGIT bits per cycle LSB first, carry held in a flop.
module serial_negate_unit #(
    parameter int WIDTH = 6,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             ovf,
    output logic             zero
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] s_next;
    logic             inv_reg;
    logic             cin_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             ovf_reg;
    logic             zero_reg;
    logic             out_valid_reg;

    logic             dec_inv;
    logic             dec_cin;
    logic [DIGIT-1:0] digit_a;
    logic [DIGIT:0]   digit_sum;
    logic             last_digit;

    always_comb begin
        dec_inv = 1'b0;
        dec_cin = 1'b0;
        case (mode)
            2'b00: begin dec_inv = 1'b0;       dec_cin = 1'b0;       end
            2'b01: begin dec_inv = 1'b1;       dec_cin = 1'b1;       end
            2'b10: begin dec_inv = a[WIDTH-1]; dec_cin = a[WIDTH-1]; end
            default: begin dec_inv = 1'b1;     dec_cin = 1'b0;       end
        endcase
    end

    always_comb begin
        digit_a = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (cnt_reg == CW'(k)) begin
                digit_a = a_reg[k*DIGIT +: DIGIT];
            end
        end
    end

    // One extra bit on the adder captures the carry into the next digit.
    assign digit_sum  = {1'b0, (inv_reg ? ~digit_a : digit_a)} + {{DIGIT{1'b0}}, carry_reg};
    assign last_digit = (cnt_reg == CW'(NDIG - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            assign s_next[gi*DIGIT +: DIGIT] = (cnt_reg == CW'(gi)) ? digit_sum[DIGIT-1:0]
                                                                     : s_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            s_reg         <= '0;
            inv_reg       <= 1'b0;
            cin_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        inv_reg   <= dec_inv;
                        cin_reg   <= dec_cin;
                        carry_reg <= dec_cin;
                        cnt_reg   <= '0;
                        s_reg     <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    s_reg     <= s_next;
                    carry_reg <= digit_sum[DIGIT];
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_digit) begin
                        // Flags use the completed result, including the digit written this cycle.
                        ovf_reg       <= inv_reg & cin_reg & a_reg[WIDTH-1] & s_next[WIDTH-1];
                        zero_reg      <= ~|s_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign s         = s_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_serial_negate_unit.sv
// Bench for serial_negate_unit: five WIDTH/DIGIT configurations share one stimulus stream,
// each checked every cycle against an arithmetic reference plus literal results on the 6/2 unit.
module tb_serial_negate_unit;
    localparam int NCFG = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [31:0]     a_bus = '0;
    logic [1:0]      mode = '0;
    logic [NCFG-1:0] vld_all;
    logic [NCFG-1:0] rdy_all;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic int cfg_w(input int i);
        case (i)
            0, 1, 2: return 6;
            3:       return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_d(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 6;
            3:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] ref_s(input logic [63:0] av, input logic [1:0] m, input int w);
        logic [63:0] mask, x, neg;
        mask = (64'd1 << w) - 64'd1;
        x    = av & mask;
        neg  = (64'd0 - x) & mask;
        case (m)
            2'd0:    return x;
            2'd1:    return neg;
            2'd2:    return x[w-1] ? neg : x;
            default: return (~x) & mask;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [63:0] av, input logic [1:0] m, input int w);
        logic [63:0] x;
        x = av & ((64'd1 << w) - 64'd1);
        return ((m == 2'd1) || (m == 2'd2 && x[w-1])) && (x == (64'd1 << (w - 1)));
    endfunction

    task automatic check(input string nm, input int inst, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cfg%0d @%0t: got %0h, want %0h", nm, inst, $time, got, want);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : cfg
            localparam int W    = cfg_w(gi);
            localparam int D    = cfg_d(gi);
            localparam int NDIG = W / D;

            logic         rdy, vld, ov, zr;
            logic [W-1:0] sv;

            serial_negate_unit #(.WIDTH(W), .DIGIT(D)) dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (rdy),
                .a         (a_bus[W-1:0]),
                .mode      (mode),
                .out_valid (vld),
                .out_ready (out_ready),
                .s         (sv),
                .ovf       (ov),
                .zero      (zr)
            );

            assign vld_all[gi] = vld;
            assign rdy_all[gi] = rdy;

            // Reference: one outstanding operation, result due NDIG edges after accept.
            bit          busy_m = 1'b0;
            bit          ev;
            longint      cyc = 0;
            longint      acc = 0;
            logic [63:0] es = '0;
            logic        eo = 1'b0;

            initial forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    busy_m = 1'b0;
                end else begin
                    if (busy_m) begin
                        if ((cyc - acc) >= NDIG && out_ready) busy_m = 1'b0;
                    end else if (in_valid) begin
                        busy_m = 1'b1;
                        acc    = cyc + 1;
                        es     = ref_s({32'd0, a_bus}, mode, W);
                        eo     = ref_ovf({32'd0, a_bus}, mode, W);
                    end
                    cyc++;
                end
            end

            initial forever begin
                @(negedge clk);
                if (!rst_n) begin
                    check("rst_out_valid", gi, 64'(vld), 64'd0);
                    check("rst_in_ready", gi, 64'(rdy), 64'd1);
                    check("rst_s", gi, 64'(sv), 64'd0);
                    check("rst_flags", gi, {62'd0, ov, zr}, 64'd0);
                end else begin
                    ev = busy_m && ((cyc - acc) >= NDIG);
                    check("out_valid", gi, 64'(vld), 64'(ev));
                    check("in_ready", gi, 64'(rdy), 64'(!busy_m));
                    if (ev) begin
                        check("s", gi, 64'(sv), es);
                        check("ovf", gi, 64'(ov), 64'(eo));
                        check("zero", gi, 64'(zr), 64'(es == 64'd0));
                    end
                end
            end
        end
    endgenerate

    task automatic do_op(input logic [31:0] av, input logic [1:0] m, input int hold,
                         input bit lit, input logic [5:0] ls, input logic lo, input logic lz);
        int i;
        @(negedge clk);
        in_valid  = 1'b1;
        a_bus     = av;
        mode      = m;
        out_ready = 1'b0;
        @(negedge clk);
        for (i = 0; i < 200 && vld_all != '1; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a_bus    = $urandom;
            mode     = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        check("all_valid", 0, 64'(vld_all), 64'(5'h1f));
        if (lit) begin
            check("lit_s", 0, 64'(cfg[0].sv), 64'(ls));
            check("lit_ovf", 0, 64'(cfg[0].ov), 64'(lo));
            check("lit_zero", 0, 64'(cfg[0].zr), 64'(lz));
        end
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            a_bus    = $urandom;
            @(negedge clk);
        end
        // in_valid high on the handshake cycle must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    logic [31:0] ra;

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        do_op(32'h01, 2'b01, 0, 1'b1, 6'b111111, 1'b0, 1'b0);
        do_op(32'h20, 2'b01, 0, 1'b1, 6'b100000, 1'b1, 1'b0);
        do_op(32'h00, 2'b01, 0, 1'b1, 6'b000000, 1'b0, 1'b1);
        do_op(32'h3a, 2'b10, 0, 1'b1, 6'b000110, 1'b0, 1'b0);
        do_op(32'h05, 2'b10, 0, 1'b1, 6'b000101, 1'b0, 1'b0);
        do_op(32'h2d, 2'b00, 5, 1'b1, 6'b101101, 1'b0, 1'b0);
        do_op(32'h00, 2'b11, 0, 1'b1, 6'b111111, 1'b0, 1'b0);
        do_op(32'h20, 2'b10, 0, 1'b1, 6'b100000, 1'b1, 1'b0);

        // Reset two edges into a negate; the aborted result must never appear.
        @(negedge clk);
        in_valid = 1'b1;
        a_bus    = 32'h01;
        mode     = 2'b01;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 0, 64'(cfg[0].vld), 64'd0);
        check("mid_rst_s", 0, 64'(cfg[0].sv), 64'd0);
        check("mid_rst_in_ready", 0, 64'(cfg[0].rdy), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        do_op(32'h05, 2'b01, 0, 1'b1, 6'b111011, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 7))
                0:       ra = 32'h0000_0000;
                1:       ra = 32'h0000_0020;
                2:       ra = 32'h0000_8000;
                3:       ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            do_op(ra, 2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'b0, 6'd0, 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
